// File: rtl/tiled_ws_controller.sv
// rtl/tiled_ws_controller.sv - multi-tile weight-stationary systolic array control path
//
// Purpose: sequences LOAD -> STREAM -> NEXT for each of n_tiles weight tiles,
// driving weight/input SRAM reads, output SRAM writes and the PE control planes.
// All outputs are registered and decoded from the next state/count, so the
// values for a given (state, cnt) appear on the pins in that same cycle.
//
// Ports:
//   clk_i, rst_i (sync, active-high), start_i (rising edge), abort_i
//   i_rows_i, n_tiles_i, w_offset_i, i_offset_i, o_offset_i, o_stride_i : job config
//   busy_o, done_o                          : status
//   wb_* / ib_*                             : weight / input SRAM read ports (active-low)
//   ob_*                                    : output SRAM write port (active-low)
//   ctrl_load_o, ctrl_sum_out_o, ctrl_ps_in_o, ctrl_ps_valid_o : PE control planes
module tiled_ws_controller #(
  parameter int WIDTH     = 8,
  parameter int ROW       = 4,
  parameter int COL       = 4,
  parameter int W_SIZE    = 256,
  parameter int I_SIZE    = 256,
  parameter int O_SIZE    = 256,
  parameter int MAX_TILES = 16,
  localparam int AW = $clog2(W_SIZE),
  localparam int AI = $clog2(I_SIZE),
  localparam int AO = $clog2(O_SIZE),
  localparam int TW = $clog2(MAX_TILES) + 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic                        abort_i,
  input  logic [AI:0]                 i_rows_i,
  input  logic [TW-1:0]               n_tiles_i,
  input  logic [AW-1:0]               w_offset_i,
  input  logic [AI-1:0]               i_offset_i,
  input  logic [AO-1:0]               o_offset_i,
  input  logic [AO-1:0]               o_stride_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        wb_cenb_o,
  output logic                        wb_wenb_o,
  output logic [AW-1:0]               wb_addr_o,
  output logic                        ib_cenb_o,
  output logic                        ib_wenb_o,
  output logic [AI-1:0]               ib_addr_o,
  output logic                        ob_cenb_o,
  output logic                        ob_wenb_o,
  output logic [AO-1:0]               ob_addr_o,
  output logic [0:ROW-1][0:COL-1]     ctrl_load_o,
  output logic [0:ROW-1][0:COL-1]     ctrl_sum_out_o,
  output logic [0:ROW-1][0:COL-1]     ctrl_ps_in_o,
  output logic [0:ROW-1][0:COL-1]     ctrl_ps_valid_o
);

  // WIDTH only describes the datapath; it is checked here so a bad value is caught early.
  if (WIDTH < 1 || ROW < 1 || COL < 1) begin : g_param_check
    $error("tiled_ws_controller: WIDTH, ROW and COL must be positive");
  end

  // cnt must reach i_rows_max + ROW in STREAM.
  localparam int CW = $clog2((2 ** (AI + 1)) + ROW + 1);
  localparam logic [CW-1:0] ROW_C = CW'(ROW);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STREAM, S_NEXT, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] t_q, t_d;
  logic          start_prev_q;

  logic [AI:0]   i_rows_q, i_rows_d;
  logic [TW-1:0] n_tiles_q, n_tiles_d;
  logic [AW-1:0] w_off_q, w_off_d;
  logic [AI-1:0] i_off_q, i_off_d;
  logic [AO-1:0] o_off_q, o_off_d;
  logic [AO-1:0] o_stride_q, o_stride_d;

  logic          busy_q, busy_d, done_q, done_d;
  logic          wb_cenb_q, wb_cenb_d, ib_cenb_q, ib_cenb_d;
  logic          ob_cenb_q, ob_cenb_d, ob_wenb_q, ob_wenb_d;
  logic [AW-1:0] wb_addr_q, wb_addr_d;
  logic [AI-1:0] ib_addr_q, ib_addr_d;
  logic [AO-1:0] ob_addr_q, ob_addr_d;
  logic [0:ROW-1][0:COL-1] load_q, load_d, sum_q, sum_d, psin_q, psin_d, psv_q, psv_d;

  logic          start_edge;
  logic [CW-1:0] stream_last;
  logic [TW-1:0] last_t;
  logic [CW-1:0] ir_x;

  assign start_edge  = start_i & ~start_prev_q;
  assign stream_last = CW'(i_rows_q) + ROW_C;
  // n_tiles = 0 runs a single tile, same as n_tiles = 1.
  assign last_t      = (n_tiles_q == '0) ? '0 : n_tiles_q - TW'(1);
  assign ir_x        = CW'(i_rows_d);

  // Next state, counters and captured config.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    t_d        = t_q;
    i_rows_d   = i_rows_q;
    n_tiles_d  = n_tiles_q;
    w_off_d    = w_off_q;
    i_off_d    = i_off_q;
    o_off_d    = o_off_q;
    o_stride_d = o_stride_q;
    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d    = S_LOAD;
          cnt_d      = '0;
          t_d        = '0;
          i_rows_d   = i_rows_i;
          n_tiles_d  = n_tiles_i;
          w_off_d    = w_offset_i;
          i_off_d    = i_offset_i;
          o_off_d    = o_offset_i;
          o_stride_d = o_stride_i;
        end
      end
      S_LOAD: begin
        if (cnt_q == ROW_C) begin
          state_d = S_STREAM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STREAM: begin
        if (cnt_q == stream_last) begin
          state_d = S_NEXT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_NEXT: begin
        cnt_d = '0;
        if (t_q == last_t) begin
          state_d = S_DONE;
        end else begin
          state_d = S_LOAD;
          t_d     = t_q + TW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    // Abort overrides any start edge or progress; the job is dropped without done.
    if (abort_i) begin
      state_d    = S_IDLE;
      cnt_d      = '0;
      t_d        = '0;
      i_rows_d   = i_rows_q;
      n_tiles_d  = n_tiles_q;
      w_off_d    = w_off_q;
      i_off_d    = i_off_q;
      o_off_d    = o_off_q;
      o_stride_d = o_stride_q;
    end
  end

  // Output decode from the next state so the registered pins line up with (state, cnt).
  always_comb begin
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    wb_cenb_d = 1'b1;
    ib_cenb_d = 1'b1;
    ob_cenb_d = 1'b1;
    ob_wenb_d = 1'b1;
    wb_addr_d = '0;
    ib_addr_d = '0;
    ob_addr_d = '0;
    load_d    = '0;
    sum_d     = '0;
    psin_d    = '0;
    psv_d     = '0;
    case (state_d)
      S_LOAD: begin
        if (cnt_d < ROW_C) begin
          wb_cenb_d = 1'b0;
          wb_addr_d = w_off_d + AW'(32'(t_d) * 32'(ROW)) + AW'(cnt_d);
        end
        if (cnt_d == ROW_C) begin
          load_d = '1;
        end
      end
      S_STREAM: begin
        sum_d     = '1;
        psin_d[0] = '1;
        if (cnt_d < ir_x) begin
          ib_cenb_d = 1'b0;
          ib_addr_d = i_off_d + AI'(cnt_d);
        end
        // Results leave the bottom row ROW+1 cycles after their input row entered.
        if (cnt_d > ROW_C) begin
          ob_cenb_d = 1'b0;
          ob_wenb_d = 1'b0;
          ob_addr_d = o_off_d + AO'(32'(t_d) * 32'(o_stride_d))
                      + AO'(32'(cnt_d) - 32'(ROW + 1));
        end
        // Valid wavefront: row r sees its i_rows partial sums starting at cnt = r+1.
        for (int r = 0; r < ROW; r++) begin
          if (cnt_d >= CW'(r + 1) && cnt_d <= CW'(r) + ir_x) begin
            psv_d[r] = '1;
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      t_q          <= '0;
      start_prev_q <= 1'b0;
      i_rows_q     <= '0;
      n_tiles_q    <= '0;
      w_off_q      <= '0;
      i_off_q      <= '0;
      o_off_q      <= '0;
      o_stride_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      wb_cenb_q    <= 1'b1;
      ib_cenb_q    <= 1'b1;
      ob_cenb_q    <= 1'b1;
      ob_wenb_q    <= 1'b1;
      wb_addr_q    <= '0;
      ib_addr_q    <= '0;
      ob_addr_q    <= '0;
      load_q       <= '0;
      sum_q        <= '0;
      psin_q       <= '0;
      psv_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      t_q          <= t_d;
      start_prev_q <= start_i;
      i_rows_q     <= i_rows_d;
      n_tiles_q    <= n_tiles_d;
      w_off_q      <= w_off_d;
      i_off_q      <= i_off_d;
      o_off_q      <= o_off_d;
      o_stride_q   <= o_stride_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      wb_cenb_q    <= wb_cenb_d;
      ib_cenb_q    <= ib_cenb_d;
      ob_cenb_q    <= ob_cenb_d;
      ob_wenb_q    <= ob_wenb_d;
      wb_addr_q    <= wb_addr_d;
      ib_addr_q    <= ib_addr_d;
      ob_addr_q    <= ob_addr_d;
      load_q       <= load_d;
      sum_q        <= sum_d;
      psin_q       <= psin_d;
      psv_q        <= psv_d;
    end
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign wb_cenb_o       = wb_cenb_q;
  assign wb_wenb_o       = 1'b1;
  assign wb_addr_o       = wb_addr_q;
  assign ib_cenb_o       = ib_cenb_q;
  assign ib_wenb_o       = 1'b1;
  assign ib_addr_o       = ib_addr_q;
  assign ob_cenb_o       = ob_cenb_q;
  assign ob_wenb_o       = ob_wenb_q;
  assign ob_addr_o       = ob_addr_q;
  assign ctrl_load_o     = load_q;
  assign ctrl_sum_out_o  = sum_q;
  assign ctrl_ps_in_o    = psin_q;
  assign ctrl_ps_valid_o = psv_q;

endmodule
